chan_fifo_reader_mf: RTL and testbench

//  Per-channel TX packet reader, parametrised successor of the single-format channel reader. Sits between the

---
 rtl/chan_fifo_reader_mf.sv | 199 +++++++++++++++++++
 tb/tb_chan_fifo_reader_mf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_fifo_reader_mf.sv
// rtl/chan_fifo_reader_mf.sv - per-channel TX packet reader: header/timestamp parse, time and RSSI gating,
// QI16/QI8 sample streaming on tx_strobe with burst underrun tracking.
module chan_fifo_reader_mf #(
    parameter int SAMPLE_W = 16,
    parameter int TS_W     = 32,
    parameter int UCNT_W   = 16
) (
    input  logic                tx_clock,
    input  logic                reset_n,
    input  logic                tx_strobe,
    input  logic [TS_W-1:0]     timestamp_clock,
    input  logic [3:0]          samples_format,
    input  logic [31:0]         fifodata,
    input  logic                pkt_waiting,
    output logic                rdreq,
    output logic                skip,
    output logic [SAMPLE_W-1:0] tx_i,
    output logic [SAMPLE_W-1:0] tx_q,
    output logic                tx_empty,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_count,
    input  logic [31:0]         rssi,
    input  logic [31:0]         threshold,
    input  logic [15:0]         rssi_timeout,
    output logic                burst
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HEADER     = 3'd1,
        TIMESTAMP  = 3'd2,
        RSSI_WAIT  = 3'd3,
        WAIT       = 3'd4,
        WAITSTROBE = 3'd5,
        SEND       = 3'd6
    } state_t;

    state_t          state;
    logic            trash;
    logic            gate;
    logic            fmt8;
    logic            half;
    logic [6:0]      payload_len;
    logic [6:0]      read_len;
    logic [TS_W-1:0] ts_reg;
    logic [15:0]     rssi_cnt;

    logic            hdr_start;
    logic            hdr_end;
    logic [TS_W-1:0] ts_diff;
    logic [15:0]     src_i;
    logic [15:0]     src_q;

    assign hdr_start = fifodata[28];
    assign hdr_end   = fifodata[27];
    assign ts_diff   = ts_reg - timestamp_clock;

    // Sources are built 16 bits wide, MSB-aligned, then truncated to SAMPLE_W.
    always_comb begin
        src_i = fifodata[15:0];
        src_q = fifodata[31:16];
        if (fmt8) begin
            if (!half) begin
                src_i = {fifodata[7:0], 8'h00};
                src_q = {fifodata[15:8], 8'h00};
            end else begin
                src_i = {fifodata[23:16], 8'h00};
                src_q = {fifodata[31:24], 8'h00};
            end
        end
    end

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rdreq          <= 1'b0;
            skip           <= 1'b0;
            tx_i           <= '0;
            tx_q           <= '0;
            tx_empty       <= 1'b1;
            underrun       <= 1'b0;
            underrun_count <= '0;
            burst          <= 1'b0;
            trash          <= 1'b0;
            gate           <= 1'b0;
            fmt8           <= 1'b0;
            half           <= 1'b0;
            payload_len    <= '0;
            read_len       <= '0;
            ts_reg         <= '0;
            rssi_cnt       <= '0;
        end else begin
            skip <= 1'b0;
            if (tx_strobe && state != SEND) begin
                tx_empty <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx_i <= '0;
                    tx_q <= '0;
                    if (pkt_waiting) begin
                        rdreq    <= 1'b1;
                        underrun <= 1'b0;
                        state    <= HEADER;
                    end else if (burst) begin
                        underrun <= 1'b1;
                        if (!underrun && !(&underrun_count)) begin
                            underrun_count <= underrun_count + UCNT_W'(1);
                        end
                    end
                end

                HEADER: begin
                    if (hdr_start) begin
                        burst <= !hdr_end;
                    end else if (hdr_end) begin
                        burst <= 1'b0;
                    end
                    // A late start packet poisons the rest of its burst until the next start.
                    if (trash && !hdr_start) begin
                        skip  <= 1'b1;
                        rdreq <= 1'b0;
                        state <= IDLE;
                    end else begin
                        payload_len <= fifodata[8:2];
                        read_len    <= '0;
                        if (hdr_start) begin
                            trash <= 1'b0;
                        end
                        gate  <= fifodata[26] & hdr_start;
                        fmt8  <= (samples_format == 4'd1);
                        half  <= 1'b0;
                        state <= TIMESTAMP;
                    end
                end

                TIMESTAMP: begin
                    ts_reg   <= fifodata[TS_W-1:0];
                    rdreq    <= 1'b0;
                    rssi_cnt <= '0;
                    state    <= gate ? RSSI_WAIT : WAIT;
                end

                RSSI_WAIT: begin
                    if (rssi <= threshold) begin
                        state <= WAIT;
                    end else if (rssi_timeout != 16'd0 && rssi_cnt + 16'd1 == rssi_timeout) begin
                        trash <= 1'b1;
                        skip  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        rssi_cnt <= rssi_cnt + 16'd1;
                    end
                end

                WAIT: begin
                    if ((&ts_reg) || ts_diff == '0) begin
                        state <= WAITSTROBE;
                    end else if (ts_diff[TS_W-1]) begin
                        trash <= 1'b1;
                        skip  <= 1'b1;
                        state <= IDLE;
                    end
                end

                WAITSTROBE: begin
                    rdreq <= 1'b0;
                    if (read_len == payload_len) begin
                        skip  <= 1'b1;
                        state <= IDLE;
                    end else if (tx_strobe) begin
                        state <= SEND;
                    end
                end

                SEND: begin
                    tx_i     <= src_i[15 -: SAMPLE_W];
                    tx_q     <= src_q[15 -: SAMPLE_W];
                    tx_empty <= 1'b0;
                    if (fmt8 && !half) begin
                        half <= 1'b1;
                    end else begin
                        half     <= 1'b0;
                        rdreq    <= 1'b1;
                        read_len <= read_len + 7'd1;
                    end
                    state <= WAITSTROBE;
                end

                default: begin
                    rdreq <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_fifo_reader_mf.sv
// tb/tb_chan_fifo_reader_mf.sv - scoreboard bench: FIFO/packet model, random and directed packets.
module tb_chan_fifo_reader_mf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tx_strobe;
    logic [31:0] timestamp_clock;
    logic [3:0]  samples_format;
    logic [31:0] fifodata;
    logic        pkt_waiting;
    logic        rdreq;
    logic        skip;
    logic [15:0] tx_i;
    logic [15:0] tx_q;
    logic        tx_empty;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [31:0] rssi;
    logic [31:0] threshold;
    logic [15:0] rssi_timeout;
    logic        burst;

    chan_fifo_reader_mf dut (
        .tx_clock        (clk),
        .reset_n         (reset_n),
        .tx_strobe       (tx_strobe),
        .timestamp_clock (timestamp_clock),
        .samples_format  (samples_format),
        .fifodata        (fifodata),
        .pkt_waiting     (pkt_waiting),
        .rdreq           (rdreq),
        .skip            (skip),
        .tx_i            (tx_i),
        .tx_q            (tx_q),
        .tx_empty        (tx_empty),
        .underrun        (underrun),
        .underrun_count  (underrun_count),
        .rssi            (rssi),
        .threshold       (threshold),
        .rssi_timeout    (rssi_timeout),
        .burst           (burst)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] cyc;
    logic [31:0] ts_base = 32'd0;
    assign timestamp_clock = ts_base + cyc;

    logic [31:0] pend_words[$];
    int          pend_lens[$];
    logic [31:0] open_words[$];
    bit          open_act;
    logic [31:0] exp_q[$];
    int          rd_total = 0;
    int          skip_total = 0;
    logic [31:0] last_rd_cyc = 0;
    logic [31:0] skip_cyc = 0;
    logic [31:0] last_pop_tclk = 0;
    logic [31:0] dir_words[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Packet FIFO model: show-ahead word, rdreq advances, skip drops the open packet.
    initial begin : fifo_model
        bit r, s;
        int n, scnt;
        logic [31:0] tmp;
        fifodata = 0; pkt_waiting = 0; tx_strobe = 0; cyc = 0; open_act = 0; scnt = 2;
        forever begin
            @(negedge clk);
            r = rdreq;
            s = skip;
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (!reset_n) begin
                pend_words.delete(); pend_lens.delete(); open_words.delete(); open_act = 0;
            end else begin
                if (r) begin
                    rd_total++;
                    last_rd_cyc = cyc;
                    if (!open_act && pend_lens.size() > 0) begin
                        n = pend_lens.pop_front();
                        for (int k = 0; k < n; k++) open_words.push_back(pend_words.pop_front());
                        open_act = 1;
                    end
                    if (open_words.size() > 0) tmp = open_words.pop_front();
                end
                if (s) begin
                    skip_total++;
                    skip_cyc = cyc;
                    open_words.delete();
                    open_act = 0;
                end
            end
            if (scnt == 0) begin
                tx_strobe = 1'b1;
                scnt = $urandom_range(3, 7);
            end else begin
                tx_strobe = 1'b0;
                scnt--;
            end
            if (open_act) fifodata = (open_words.size() > 0) ? open_words[0] : 32'd0;
            else          fifodata = (pend_words.size() > 0) ? pend_words[0] : 32'd0;
            pkt_waiting = (pend_lens.size() > 0);
        end
    end

    // Monitor: each fall of tx_empty presents one sample.
    initial begin : monitor
        bit prev_empty;
        logic [31:0] e;
        prev_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && prev_empty && tx_empty === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_sample actual=0x%h required=none", {tx_q, tx_i});
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_q, tx_i} !== e) begin
                        fails++;
                        $display("FAIL sample actual=0x%h required=0x%h", {tx_q, tx_i}, e);
                    end
                end
                last_pop_tclk = timestamp_clock;
            end
            prev_empty = tx_empty;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] header(bit st, bit en, bit gt, int len);
        header = {3'b000, st, en, gt, 17'd0, len[6:0], 2'b00};
    endfunction

    // Expected samples straight from the format rules: {q,i} per strobe.
    task automatic push_expect(input logic [31:0] w, input int fmt);
        if (fmt == 1) begin
            exp_q.push_back({w[15:8], 8'h00, w[7:0], 8'h00});
            exp_q.push_back({w[31:24], 8'h00, w[23:16], 8'h00});
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic push_pkt(input bit st, en, gt, input int len, input logic [31:0] ts,
                            input bit sent, input bit use_dir);
        logic [31:0] w;
        pend_words.push_back(header(st, en, gt, len));
        pend_words.push_back(ts);
        for (int k = 0; k < len; k++) begin
            w = use_dir ? dir_words[k] : $urandom;
            pend_words.push_back(w);
            if (sent) push_expect(w, int'(samples_format));
        end
        pend_lens.push_back(len + 2);
    endtask

    task automatic wait_skip(input string name);
        int base, n;
        base = skip_total;
        n = 0;
        while (skip_total == base && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_skip_seen"}, skip_total != base, 1);
    endtask

    task automatic run_pkt(input string name, input bit st, en, gt, input int len,
                           input logic [31:0] ts, input bit sent, input bit use_dir, input int exp_rd);
        int rd0;
        rd0 = rd_total;
        push_pkt(st, en, gt, len, ts, sent, use_dir);
        wait_skip(name);
        repeat (3) @(negedge clk);
        chk({name, "_rdreq_words"}, rd_total - rd0, exp_rd);
        chk({name, "_samples_left"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {rdreq, skip, tx_i, tx_q, tx_empty, underrun, underrun_count, burst},
            {1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0});
    endtask

    initial begin : main
        int len, fmt, rd0, n;
        logic [31:0] delta;
        reset_n = 1'b0; samples_format = 4'd0;
        rssi = 32'd0; threshold = 32'd100; rssi_timeout = 16'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int p = 0; p < 8; p++) begin
            fmt = $urandom_range(0, 2);
            len = $urandom_range(1, 6);
            samples_format = fmt[3:0];
            run_pkt($sformatf("rand%0d", p), 1, 1, 0, len, 32'hFFFF_FFFF, 1, 0, len + 2);
        end

        samples_format = 4'd0;
        dir_words = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005};
        run_pkt("qi16_dir", 1, 1, 0, 3, 32'hFFFF_FFFF, 1, 1, 5);
        n = 0;
        while (tx_strobe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("qi16_empty_after", tx_empty, 1);

        samples_format = 4'd1;
        dir_words = '{32'h4433_2211};
        run_pkt("qi8_dir", 1, 1, 0, 1, 32'hFFFF_FFFF, 1, 1, 3);

        samples_format = 4'd0;
        ts_base = 32'hFFFF_FFF0 - cyc;
        run_pkt("wrap", 1, 1, 0, 1, 32'h0000_0005, 1, 0, 3);
        delta = last_pop_tclk - 32'h0000_0005;
        chk("wrap_send_time", (delta >= 1 && delta <= 16), 1);

        ts_base = 32'hFFFF_FFF0 - cyc;
        rd0 = rd_total;
        push_pkt(1, 0, 0, 2, 32'hFFFF_FFE0, 0, 0);
        push_pkt(0, 1, 0, 2, 32'hFFFF_FFFF, 0, 0);
        push_pkt(1, 1, 0, 2, 32'hFFFF_FFFF, 1, 0);
        wait_skip("late");
        wait_skip("trash_mid");
        wait_skip("after_trash");
        repeat (3) @(negedge clk);
        chk("late_rdreq_words", rd_total - rd0, 7);
        chk("late_samples_left", exp_q.size(), 0);
        chk("late_burst", burst, 0);
        chk("late_no_underrun", underrun_count, 0);

        rssi = 32'd200; rssi_timeout = 16'd10;
        run_pkt("rssi_timeout", 1, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 2);
        delta = skip_cyc - last_rd_cyc;
        chk("rssi_timeout_delay", (delta >= 10 && delta <= 12), 1);
        fork
            run_pkt("rssi_pass", 1, 1, 1, 2, 32'hFFFF_FFFF, 1, 0, 4);
            begin repeat (8) @(negedge clk); rssi = 32'd50; end
        join
        rssi = 32'd0;

        run_pkt("zero_len", 1, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 2);

        run_pkt("burst_start", 1, 0, 0, 2, 32'hFFFF_FFFF, 1, 0, 4);
        repeat (4) @(negedge clk);
        chk("underrun_1", underrun, 1);
        run_pkt("burst_mid1", 0, 0, 0, 2, 32'hFFFF_FFFF, 1, 0, 4);
        repeat (4) @(negedge clk);
        run_pkt("burst_mid2", 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 3);
        repeat (4) @(negedge clk);
        chk("underrun_count", underrun_count, 3);
        chk("underrun_open", {burst, underrun}, 2'b11);

        reset_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_burst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        samples_format = 4'd1;
        run_pkt("post_reset", 1, 1, 0, 3, 32'hFFFF_FFFF, 1, 0, 5);
        chk("post_reset_count", underrun_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
